// File: rtl/fas_serial.sv
// Bit-serial adder/subtractor. One operand bit per clock, LSB first, with a
// registered carry/borrow. Results are published only when the last bit is done.

module fas_bit (
    input  logic ai,
    input  logic bi,
    input  logic c,
    input  logic sub,
    output logic sum,
    output logic co
);
    always_comb begin
        sum = ai ^ bi ^ c;
        co  = sub ? ((~ai & (bi | c)) | (bi & c))
                  : ((ai & bi) | (c & (ai | bi)));
    end
endmodule

module fas_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [CW-1:0]    cnt;
    logic             c_r, sub_r;
    logic             sum, co, last;

    fas_bit u_bit (
        .ai  (a_sh[0]),
        .bi  (b_sh[0]),
        .c   (c_r),
        .sub (sub_r),
        .sum (sum),
        .co  (co)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RUN : IDLE;
            RUN:        if (last) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            c_r   <= 1'b0;
            sub_r <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state != RUN && start) begin
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= ~a_ns;
            c_r   <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c_r  <= co;
            cnt  <= cnt + CW'(1);
            // Partial sums stay in s_sh; s only moves on the final bit.
            s_sh <= (s_sh >> 1) | ((WIDTH-1)'(sum) << (WIDTH - 2));
            if (last) begin
                s    <= {sum, s_sh};
                cout <= co;
                // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
                ovf  <= sub_r ? ((a_sh[0] != b_sh[0]) && (sum != a_sh[0]))
                              : ((a_sh[0] == b_sh[0]) && (sum != a_sh[0]));
            end
        end
    end
endmodule

// File: tb/tb_fas_serial.sv
// Directed checks of fas_serial (WIDTH=8): arithmetic, latency, start
// masking during RUN, back-to-back starts and mid-operation reset.

module tb_fas_serial;
    logic       clk = 1'b0;
    logic       rst, start, a_ns, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] s;
    int         checks = 0;
    int         errors = 0;
    int         cyc, bc, seen;

    fas_serial #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_ns(a_ns), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the start edge.
    task automatic launch(input logic add, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci);
        start = 1'b1; a_ns = add; a = av; b = bv; cin = ci;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int bcount);
        c = 0; bcount = 0;
        while (done !== 1'b1 && c < 40) begin
            if (busy === 1'b1) bcount++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic op(input string tag, input logic add, input logic [7:0] av,
                      input logic [7:0] bv, input logic ci, input logic [7:0] es,
                      input logic ec, input logic eo);
        launch(add, av, bv, ci);
        wait_done(cyc, bc);
        chk({tag, "_lat"}, cyc, 8);
        chk({tag, "_busy"}, bc, 8);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        chk({tag, "_done1"}, done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_ns = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_flags", {cout, ovf}, 0);
        rst = 1'b0;
        @(negedge clk);

        op("add0f01",   1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        op("addff01c",  1'b1, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
        op("add7f01",   1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op("sub0507",   1'b0, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);
        op("sub8001",   1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op("sub1005b",  1'b0, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0);
        op("sub0000b",  1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start pulsed during RUN must be ignored
        launch(1'b1, 8'h10, 8'h20, 1'b0);
        @(negedge clk); @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bc);
        chk("ign_lat", cyc, 5);
        chk("ign_s", s, 8'h30);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("ign_single_done", seen, 0);
        chk("ign_idle", busy, 0);

        // back-to-back: second start in the done cycle
        launch(1'b1, 8'h0F, 8'h01, 1'b0);
        wait_done(cyc, bc);
        chk("b2b_first_s", s, 8'h10);
        launch(1'b1, 8'h22, 8'h11, 1'b0);
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_s", s, 8'h10);
        repeat (4) @(negedge clk);
        chk("b2b_hold_mid", s, 8'h10);
        wait_done(cyc, bc);
        chk("b2b_lat", cyc, 4);
        chk("b2b_s", s, 8'h33);
        @(negedge clk);

        // reset during RUN aborts with no done pulse
        launch(1'b1, 8'h55, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s", s, 0);
        chk("abort_flags", {cout, ovf}, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_quiet", seen, 0);
        op("post_rst", 1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fas_serial.md
FAS_SERIAL -- requirements
Module: fas_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an operation, sampled on clk.
REQ-005 The block SHALL have port a_ns  input  1  mode: 1 = add, 0 = subtract (a - b).
REQ-006 The block SHALL have port a  input  WIDTH  operand A.
REQ-007 The block SHALL have port b  input  WIDTH  operand B.
REQ-008 The block SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-009 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse marking a new valid result.
REQ-011 The block SHALL have port s  output  WIDTH  result.
REQ-012 The block SHALL have port cout  output  1  carry-out (add) / borrow-out (subtract).
REQ-013 The block SHALL have port ovf  output  1  two's-complement signed overflow flag.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE with rst=0 and start=1, the block SHALL latch a, b, a_ns and cin, clear the bit counter, and enter RUN on that edge.
REQ-016 The block SHALL ignore start while in RUN; latched operands SHALL NOT change until the next accepted start.
REQ-017 In RUN, each clock edge SHALL process exactly one bit, LSB first, through one full adder/subtractor stage with a registered carry/borrow.
REQ-018 Per bit, the block SHALL compute sum = ai ^ bi ^ c; add carry = (ai&bi)|(c&(ai|bi)); subtract borrow = (~ai&(bi|c))|(bi&c).
REQ-019 After the WIDTH-th RUN edge, the block SHALL enter DONE; done=1 for exactly that one cycle; on the next edge it SHALL return to IDLE, or to RUN if start=1.
REQ-020 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH, and busy SHALL be high from edge k+1 through edge k+WIDTH (exactly WIDTH cycles).
REQ-021 In add mode, {cout,s} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-022 In subtract mode, s SHALL equal (a - b - cin) mod 2^WIDTH, and cout SHALL be 1 iff unsigned a < b + cin.
REQ-023 In add mode, ovf SHALL be 1 iff a[MSB]==b[MSB] and s[MSB]!=a[MSB]; in subtract mode, ovf SHALL be 1 iff a[MSB]!=b[MSB] and s[MSB]!=a[MSB].
REQ-024 s, cout and ovf SHALL update only on the edge entering DONE and SHALL hold until the next completion; partial results SHALL NOT be visible.
REQ-025 Back-to-back: a start accepted in the DONE cycle SHALL begin a new RUN with no idle gap, and the outputs SHALL hold the previous result until the new completion.

Reset
REQ-026 rst SHALL take priority over start and all FSM activity.
REQ-027 On a rst edge, the block SHALL set state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and clear the counter and carry register.
REQ-028 A rst during RUN SHALL abort the operation; no done pulse SHALL follow, and the next start SHALL behave as from power-up.

Verification (WIDTH=8)
REQ-029 Add, a=0x0F, b=0x01, cin=0 -> s=0x10, cout=0, ovf=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
REQ-030 Add, a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1, ovf=0; add, a=0x7F, b=0x01, cin=0 -> s=0x80, cout=0, ovf=1.
REQ-031 Subtract, a=0x05, b=0x07, cin=0 -> s=0xFE, cout=1, ovf=0; subtract, a=0x80, b=0x01, cin=0 -> s=0x7F, cout=0, ovf=1.
REQ-032 start with a=0x10, b=0x20 (add); in RUN cycle 3, start=1 with a=0xAA -> ignored; result s=0x30 with a single done pulse.
REQ-033 Back-to-back: second start in the done cycle -> second done exactly 8 cycles later; s holds the first result until then.
REQ-034 rst in RUN cycle 4 -> busy=0 and all outputs 0 the next cycle, no done; a following add 0x01+0x01 yields s=0x02.
